// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered ALU pipeline stage:
//   - operation codes (OP_ADD .. OP_MUL) and the illegal op-code range
//   - control FSM state encoding (IDLE / BUSY / HOLD)
//   - small decode helper used by the top level
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_NOT    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_OR     = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SLT    = 4'd6;
    localparam logic [3:0] OP_SEQ    = 4'd7;
    localparam logic [3:0] OP_SLL    = 4'd8;
    localparam logic [3:0] OP_SRL    = 4'd9;
    localparam logic [3:0] OP_SRA    = 4'd10;
    localparam logic [3:0] OP_MUL    = 4'd11;
    localparam logic [3:0] OP_ILL_LO = 4'd12;
    localparam logic [3:0] OP_ILL_HI = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // MUL only counts as a multi-cycle op when the multiplier is built in.
    function automatic logic op_is_mul(input logic [3:0] op_code, input logic mul_en);
        return (op_code == OP_MUL) && mul_en;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Unsigned iterative shift-add multiplier, one multiplier bit per clock.
// A start pulse captures the operands; WIDTH clocks later done is high and
// product holds the full 2*WIDTH-bit result. done stays high until the next
// start.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and begin iterating
//   a, b         WIDTH-bit unsigned operands (sampled on start)
//   done         product valid
//   product      2*WIDTH-bit unsigned product
// -----------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_s;

    assign done_s  = busy_r && (cnt_r == CNT_W'(WIDTH));
    assign done    = done_s;
    assign product = acc_r;

    // Operand capture on start, then one conditional add and shift per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= '0;
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
        end else if (busy_r && !done_s) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Registered ALU stage between operand/decode and writeback, with valid/ready
// handshakes on both sides. Single-cycle ops land in the output register on
// the accept edge; MUL runs on alu_mul_iter and lands WIDTH+1 edges later.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (transfer on in_valid && in_ready)
//   op, a, b              op code and WIDTH-bit operands
//   out_valid / out_ready output handshake (transfer on out_valid && out_ready)
//   result                registered WIDTH-bit result
//   overflow, carry, zero, negative, err   registered flags
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             err
);

    localparam int SH_W = $clog2(WIDTH);

    state_t               state_r;
    state_t               state_s;
    logic                 accept_s;
    logic                 is_mul_s;
    logic                 mul_start_s;
    logic                 mul_done_s;
    logic [2*WIDTH-1:0]   product_s;

    logic [SH_W-1:0]      amt_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       diff_s;
    logic [WIDTH:0]       sll_s;
    logic [WIDTH:0]       srl_s;
    logic [WIDTH:0]       sra_s;

    logic [WIDTH-1:0]     res_s;
    logic                 ovf_s;
    logic                 cry_s;
    logic                 err_s;

    logic [WIDTH-1:0]     result_r;
    logic                 overflow_r;
    logic                 carry_r;
    logic                 zero_r;
    logic                 negative_r;
    logic                 err_r;
    logic                 out_valid_r;

    // In HOLD a new op may be taken on the same edge the consumer drains the result.
    assign in_ready    = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && out_ready);
    assign accept_s    = in_valid && in_ready;
    assign is_mul_s    = op_is_mul(op, MUL_EN);
    assign mul_start_s = accept_s && is_mul_s;

    assign amt_s  = b[SH_W-1:0];
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};
    // One guard bit beside the operand catches the last bit shifted out;
    // a zero shift leaves the guard bit at 0, so carry is 0 as well.
    assign sll_s  = {1'b0, a} << amt_s;
    assign srl_s  = {a, 1'b0} >> amt_s;
    assign sra_s  = $signed({a, 1'b0}) >>> amt_s;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (product_s)
    );

    // Single-cycle datapath: result and overflow/carry/err for the presented op.
    always_comb begin
        res_s = '0;
        ovf_s = 1'b0;
        cry_s = 1'b0;
        err_s = 1'b0;
        case (op)
            OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                cry_s = sum_s[WIDTH];
                ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_s = diff_s[WIDTH-1:0];
                cry_s = diff_s[WIDTH];
                ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: res_s = ~a;
            OP_AND: res_s = a & b;
            OP_OR:  res_s = a | b;
            OP_XOR: res_s = a ^ b;
            OP_SLT: res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SEQ: res_s = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_SLL: begin
                res_s = sll_s[WIDTH-1:0];
                cry_s = sll_s[WIDTH];
            end
            OP_SRL: begin
                res_s = srl_s[WIDTH:1];
                cry_s = srl_s[0];
            end
            OP_SRA: begin
                res_s = sra_s[WIDTH:1];
                cry_s = sra_s[0];
            end
            // With the multiplier present the result comes from u_mul instead.
            OP_MUL: err_s = !MUL_EN;
            default: err_s = 1'b1;
        endcase
    end

    // Next-state logic for the IDLE/BUSY/HOLD control FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = is_mul_s ? ST_BUSY : ST_HOLD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_done_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    state_s = is_mul_s ? ST_BUSY : ST_HOLD;
                end else if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register and registered out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s == ST_HOLD);
        end
    end

    // Output register: loads on a single-cycle accept or on multiplier completion,
    // otherwise holds so the result stays stable under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r   <= '0;
            overflow_r <= 1'b0;
            carry_r    <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
            err_r      <= 1'b0;
        end else if (state_r == ST_BUSY) begin
            if (mul_done_s) begin
                result_r   <= product_s[WIDTH-1:0];
                overflow_r <= |product_s[2*WIDTH-1:WIDTH];
                carry_r    <= 1'b0;
                zero_r     <= (product_s[WIDTH-1:0] == '0);
                negative_r <= product_s[WIDTH-1];
                err_r      <= 1'b0;
            end
        end else if (accept_s && !is_mul_s) begin
            result_r   <= res_s;
            overflow_r <= ovf_s;
            carry_r    <= cry_s;
            // An illegal op reports only err; zero stays clear despite result 0.
            zero_r     <= (res_s == '0) && !err_s;
            negative_r <= res_s[WIDTH-1];
            err_r      <= err_s;
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;
    assign carry     = carry_r;
    assign zero      = zero_r;
    assign negative  = negative_r;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Directed bench for alu_pipe (WIDTH=8). Stimulus pushes hand-computed expected
// {result, overflow, carry, zero, negative, err} into a queue at each accept; a
// negedge monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       overflow, carry, zero, negative, err;

    typedef struct {
        string       name;
        logic [12:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ev(input logic [7:0] r, input logic o, input logic c,
                                       input logic z, input logic n, input logic e);
        return {r, o, c, z, n, e};
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Present one op, wait (bounded) for in_ready, record the expectation at accept.
    task automatic send(input string nm, input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [12:0] e);
        int   n;
        exp_t t;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        #1;
        n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_%s: in_ready never rose", nm);
            in_valid = 1'b0;
        end else begin
            t.name = nm;
            t.val  = e;
            sb.push_back(t);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = 8'h55;
            b = 8'hAA;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 16'(sb.size()), 16'd0);
    endtask

    // Monitor: an output transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got result %h with nothing expected", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, {3'b000, result, overflow, carry, zero, negative, err}, {3'b000, e.val});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("reset_outputs", {3'b000, out_valid, result, overflow, carry, zero, negative, err}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 16'(in_ready), 16'd1);
        @(posedge clk);
        #1;

        // 1: add
        send("add_7f_01", 4'd0, 8'h7F, 8'h01, ev(8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        check("add_latency", 16'(out_valid), 16'd1);
        @(posedge clk);
        #1;
        send("add_ff_01", 4'd0, 8'hFF, 8'h01, ev(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        // 2: sub / compare
        send("sub_00_01", 4'd1, 8'h00, 8'h01, ev(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        send("sub_80_01", 4'd1, 8'h80, 8'h01, ev(8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send("slt_80_01", 4'd6, 8'h80, 8'h01, ev(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        send("seq_3c_3c", 4'd7, 8'h3C, 8'h3C, ev(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        // 3: shifts and illegal op
        send("sll_81_01", 4'd8, 8'h81, 8'h01, ev(8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        send("sra_80_07", 4'd10, 8'h80, 8'h07, ev(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        send("srl_80_07", 4'd9, 8'h80, 8'h07, ev(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        send("srl_81_01", 4'd9, 8'h81, 8'h01, ev(8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        send("sll_amt0", 4'd8, 8'h81, 8'h00, ev(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        send("illegal_c", 4'hC, 8'h12, 8'h34, ev(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

        // 4: multiply latency and busy behaviour
        send("mul_0f_11", 4'd11, 8'h0F, 8'h11, ev(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("mul_busy", {14'd0, out_valid, in_ready}, 16'd0);
        end
        @(negedge clk);
        check("mul_latency", 16'(out_valid), 16'd1);
        @(posedge clk);
        #1;
        send("mul_10_10", 4'd11, 8'h10, 8'h10, ev(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        drain();

        // 5: back-pressure then back-to-back transfer
        out_ready = 1'b0;
        send("add_01_02", 4'd0, 8'h01, 8'h02, ev(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_stable", {6'd0, out_valid, in_ready, result}, {6'd0, 1'b1, 1'b0, 8'h03});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send("xor_f0_0f", 4'd5, 8'hF0, 8'h0F, ev(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        drain();

        // 6: reset in the middle of a multiply
        send("mul_victim", 4'd11, 8'h03, 8'h05, ev(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("reset_mid_mul", {3'b000, out_valid, result, overflow, carry, zero, negative, err}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 16'(in_ready), 16'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 16'(out_valid), 16'd0);
        end
        @(posedge clk);
        #1;
        send("mul_03_05", 4'd11, 8'h03, 8'h05, ev(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
